s2mm_acq_ctrl: RTL and testbench
================================

# s2mm_acq_ctrl

Acquisition sequencer in front of the S2MM packetizer. It configures the packetizer's packet length, then gates the ADC sample stream into it for a programmed number of packets, or continuously. It closes the gate only on packet boundaries, waits for the final `tlast` to leave the packetizer, and reports completion with a one-cycle interrupt pulse and a packet count.

## Interface
- `DATA_W`, 32, stream data width.
- `LEN_W`, 32, width of the packet length and of `pkt_config_reg`.
- `CNT_W`, 16, width of the packet-count config and status.
- `DRAIN_TIMEOUT`, 1024, cycles allowed in DRAIN before `err_timeout`.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `cmd_start`  in  1  single-cycle start request.
- `cmd_abort`  in  1  single-cycle abort request.
- `cfg_packet_len`  in  LEN_W  words per packet; sampled on an accepted start.
- `cfg_num_packets`  in  CNT_W  packets per acquisition; sampled on an accepted start.
- `cfg_continuous`  in  1  1 = ignore `cfg_num_packets` and run until abort.
- `s_axis_tdata`, `s_axis_tvalid`, `s_axis_tready`  in/in/out  DATA_W/1/1  ADC sample stream.
- `m_axis_tdata`, `m_axis_tvalid`, `m_axis_tready`  out/out/in  DATA_W/1/1  to packetizer data input.
- `pkt_config_reg`  out  LEN_W  packet length driven to the packetizer.
- `mon_tvalid`, `mon_tready`, `mon_tlast`  in  1 each  tap on the packetizer S2MM output handshake.
- `busy`  out  1  high in every state except IDLE.
- `done_irq`  out  1  one-cycle pulse on completion.
- `packets_done`  out  CNT_W  number of packets whose `tlast` handshake has been observed.
- `err_overflow`  out  1  sticky flag: a sample was lost while running.
- `err_cfg`  out  1  one-cycle pulse when a start is rejected.
- `err_timeout`  out  1  sticky flag: the drain timed out.

## Operation
- States: IDLE, ARM, RUN, DRAIN, DONE.
- **IDLE**
  - `pkt_config_reg` = 0; gate closed (`m_axis_tvalid` = 0, `s_axis_tready` = 1, samples discarded).
  - `cmd_start` with `cfg_packet_len` ≠ 0 and (`cfg_continuous` or `cfg_num_packets` ≠ 0):
    - latches the config;
    - clears `packets_done`, `err_overflow` and `err_timeout`;
    - moves to ARM.
  - Any other start pulses `err_cfg` and stays in IDLE. Abort is ignored.
- **ARM**
  - `pkt_config_reg` = latched length; gate closed.
  - Unconditionally moves to RUN on the next edge.
- **RUN**
  - Gate open, combinational pass-through: `m_axis_tvalid` = `s_axis_tvalid`, `s_axis_tready` = `m_axis_tready`, data unchanged.
  - `beat_cnt` counts forwarded handshakes and wraps to 0 at len−1; `pkt_fwd` increments on each wrap.
  - `err_overflow` is set when `s_axis_tvalid` && !`m_axis_tready`. The ADC cannot stall, so this counts as a lost sample.
  - Leave RUN for DRAIN on the boundary handshake (`beat_cnt` = len−1) when either:
    - not continuous and `pkt_fwd`+1 = num; or
    - `abort_pend` is set.
  - The gate closes from the next cycle onward.
- **Abort in RUN**
  - Sets `abort_pend`; the current packet is completed, never truncated.
  - If `beat_cnt` = 0 and no handshake is occurring that cycle, go to DRAIN immediately.
- **DRAIN**
  - Gate closed; `pkt_config_reg` held.
  - Wait until `packets_done` = `pkt_fwd`, then go to DONE.
  - After DRAIN_TIMEOUT cycles, set `err_timeout` and go to DONE.
- **DONE**
  - `done_irq` = 1 for this cycle, then IDLE.
- **Packet counting (all states)**
  - `packets_done` increments on each cycle with `mon_tvalid` & `mon_tready` & `mon_tlast`.
  - It saturates at 2^CNT_W−1. `pkt_fwd` saturates the same way.
- **Overlapping or out-of-state commands**
  - `cmd_start` while busy is ignored; it does not pulse `err_cfg`.
  - Start and abort in the same IDLE cycle: start wins.

## Timing
- Reset values:
  - state IDLE;
  - `pkt_config_reg` 0, `m_axis_tvalid` 0, `s_axis_tready` 1;
  - `busy` 0, `done_irq` 0, `err_*` 0, `packets_done` 0.
- Start accepted at edge N: ARM at N+1, RUN at N+2. The first sample is forwarded in cycle N+2.
- Data path latency is zero cycles; no registering on the gated stream.
- Gate closing at a packet boundary is registered: the final handshake is at edge K and `m_axis_tvalid` = 0 from cycle K+1.
- `done_irq` is asserted in the cycle after the final `tlast` handshake is observed.
- Reset mid-run returns to IDLE asynchronously. Packetizer cleanup is not this block's job.

## Structure
- Package `s2mm_acq_pkg` contains:
  - the `acq_state_t` enum (IDLE, ARM, RUN, DRAIN, DONE);
  - the default widths;
  - the DRAIN_TIMEOUT default.
- The single module is an FSM plus counters.
- One natural sub-module, `acq_beat_counter`, holds the beat and packet counters with wrap and boundary detection.

## Test plan
- len=10, num=3, with the packetizer and a loopback sink:
  - 30 words forwarded, 3 `tlast`;
  - `packets_done`=3;
  - `done_irq` is one cycle, one cycle after the 3rd `tlast`;
  - `pkt_config_reg`=10 from ARM until IDLE.
- Continuous, len=8; abort at beat 3 of packet 2:
  - packet 2 completes (16 words total);
  - no further words are forwarded;
  - DONE follows, with `packets_done`=2.
- Start with len=0, and separately with num=0 and not continuous:
  - `err_cfg` pulses;
  - `busy` stays 0;
  - `pkt_config_reg` stays 0.
- Sink `tready` is held low for 5 cycles during RUN with the source always valid:
  - `err_overflow` is set and stays set;
  - it is cleared by the next start.
- `mon_tlast` never arrives, DRAIN_TIMEOUT=16:
  - DONE 16 cycles after entering DRAIN;
  - `err_timeout`=1.
- `aresetn` is asserted mid-packet:
  - all outputs take their reset values immediately;
  - a new start then runs normally.

Source files
------------

// File: rtl/s2mm_acq_pkg.sv
// ---------------------------------------------------------------------------
// s2mm_acq_pkg : shared state encoding and default widths for s2mm_acq_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package s2mm_acq_pkg;

  localparam int DEF_DATA_W        = 32;
  localparam int DEF_LEN_W         = 32;
  localparam int DEF_CNT_W         = 16;
  localparam int DEF_DRAIN_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } acq_state_t;

endpackage

`default_nettype wire

// File: rtl/s2mm_acq_ctrl_beat_counter.sv
// ---------------------------------------------------------------------------
// acq_beat_counter : beat-within-packet counter with packet-boundary detect
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module acq_beat_counter
  import s2mm_acq_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             i_clear,
  input  logic             i_fire,
  input  logic [LEN_W-1:0] i_len,
  output logic [LEN_W-1:0] o_beat_cnt,
  output logic [CNT_W-1:0] o_pkt_fwd,
  output logic             o_boundary
);

  logic [LEN_W-1:0] r_beat;
  logic [CNT_W-1:0] r_pkt_fwd;
  logic             w_last_beat;

  assign w_last_beat = (r_beat == (i_len - LEN_W'(1)));
  assign o_boundary  = i_fire && w_last_beat;
  assign o_beat_cnt  = r_beat;
  assign o_pkt_fwd   = r_pkt_fwd;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_beat    <= '0;
      r_pkt_fwd <= '0;
    end else if (i_clear) begin
      r_beat    <= '0;
      r_pkt_fwd <= '0;
    end else if (i_fire) begin
      if (w_last_beat) begin
        r_beat <= '0;
        if (r_pkt_fwd != '1) r_pkt_fwd <= r_pkt_fwd + CNT_W'(1);
      end else begin
        r_beat <= r_beat + LEN_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/s2mm_acq_ctrl.sv
// ---------------------------------------------------------------------------
// s2mm_acq_ctrl : acquisition sequencer gating an ADC stream into the packetizer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module s2mm_acq_ctrl
  import s2mm_acq_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int LEN_W         = DEF_LEN_W,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  input  logic [LEN_W-1:0]  cfg_packet_len,
  input  logic [CNT_W-1:0]  cfg_num_packets,
  input  logic              cfg_continuous,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [LEN_W-1:0]  pkt_config_reg,
  input  logic              mon_tvalid,
  input  logic              mon_tready,
  input  logic              mon_tlast,
  output logic              busy,
  output logic              done_irq,
  output logic [CNT_W-1:0]  packets_done,
  output logic              err_overflow,
  output logic              err_cfg,
  output logic              err_timeout
);

  localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);

  acq_state_t       r_state;
  logic [LEN_W-1:0] r_len;
  logic [CNT_W-1:0] r_num;
  logic             r_cont;
  logic             r_abort_pend;
  logic [TO_W-1:0]  r_drain_cnt;
  logic [CNT_W-1:0] r_pkts_done;
  logic             r_busy;
  logic             r_done_irq;
  logic             r_err_ovf;
  logic             r_err_cfg;
  logic             r_err_to;

  logic             w_gate;
  logic             w_fwd;
  logic             w_cfg_ok;
  logic             w_accept;
  logic             w_mon_last;
  logic [CNT_W-1:0] w_pkts_done_nxt;
  logic [LEN_W-1:0] w_beat_cnt;
  logic [CNT_W-1:0] w_pkt_fwd;
  logic             w_boundary;
  logic             w_count_reached;
  logic             w_abort_any;

  assign w_gate      = (r_state == RUN);
  assign w_fwd       = w_gate && s_axis_tvalid && m_axis_tready;
  assign w_cfg_ok    = (cfg_packet_len != '0) && (cfg_continuous || (cfg_num_packets != '0));
  assign w_accept    = (r_state == IDLE) && cmd_start && w_cfg_ok;
  assign w_mon_last  = mon_tvalid && mon_tready && mon_tlast;
  assign w_abort_any = r_abort_pend || cmd_abort;

  assign w_pkts_done_nxt = (w_mon_last && (r_pkts_done != '1)) ? r_pkts_done + CNT_W'(1)
                                                               : r_pkts_done;
  assign w_count_reached = !r_cont &&
                           (({1'b0, w_pkt_fwd} + (CNT_W+1)'(1)) == {1'b0, r_num});

  // Zero-latency gate: no registering on the sample path.
  assign m_axis_tdata   = s_axis_tdata;
  assign m_axis_tvalid  = w_gate && s_axis_tvalid;
  assign s_axis_tready  = w_gate ? m_axis_tready : 1'b1;

  assign pkt_config_reg = r_len;
  assign busy           = r_busy;
  assign done_irq       = r_done_irq;
  assign packets_done   = r_pkts_done;
  assign err_overflow   = r_err_ovf;
  assign err_cfg        = r_err_cfg;
  assign err_timeout    = r_err_to;

  acq_beat_counter #(
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) u_beat_counter (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .i_clear    (w_accept),
    .i_fire     (w_fwd),
    .i_len      (r_len),
    .o_beat_cnt (w_beat_cnt),
    .o_pkt_fwd  (w_pkt_fwd),
    .o_boundary (w_boundary)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_num        <= '0;
      r_cont       <= 1'b0;
      r_abort_pend <= 1'b0;
      r_drain_cnt  <= '0;
      r_pkts_done  <= '0;
      r_busy       <= 1'b0;
      r_done_irq   <= 1'b0;
      r_err_ovf    <= 1'b0;
      r_err_cfg    <= 1'b0;
      r_err_to     <= 1'b0;
    end else begin
      r_err_cfg   <= 1'b0;
      r_done_irq  <= 1'b0;
      r_pkts_done <= w_pkts_done_nxt;

      case (r_state)
        IDLE: begin
          if (cmd_start) begin
            if (w_cfg_ok) begin
              r_len        <= cfg_packet_len;
              r_num        <= cfg_num_packets;
              r_cont       <= cfg_continuous;
              r_abort_pend <= 1'b0;
              r_pkts_done  <= '0;
              r_err_ovf    <= 1'b0;
              r_err_to     <= 1'b0;
              r_busy       <= 1'b1;
              r_state      <= ARM;
            end else begin
              r_err_cfg <= 1'b1;
            end
          end
        end
        ARM: r_state <= RUN;
        RUN: begin
          // The ADC cannot be back-pressured, so a stalled valid is a lost sample.
          if (s_axis_tvalid && !m_axis_tready) r_err_ovf <= 1'b1;
          if (cmd_abort) r_abort_pend <= 1'b1;
          if ((w_boundary && (w_count_reached || w_abort_any)) ||
              (w_abort_any && (w_beat_cnt == '0) && !w_fwd)) begin
            r_drain_cnt <= '0;
            r_state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_pkts_done_nxt == w_pkt_fwd) begin
            r_done_irq <= 1'b1;
            r_state    <= DONE;
          end else if (r_drain_cnt == TO_W'(DRAIN_TIMEOUT - 1)) begin
            r_err_to   <= 1'b1;
            r_done_irq <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt + TO_W'(1);
          end
        end
        DONE: begin
          r_len   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_s2mm_acq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_s2mm_acq_ctrl : directed bench with a source, sink and packetizer tlast model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_s2mm_acq_ctrl;

  localparam int DW = 32;
  localparam int LW = 32;
  localparam int CW = 16;
  localparam int TO = 16;

  logic          aclk    = 1'b0;
  logic          aresetn = 1'b0;
  logic          cmd_start = 1'b0;
  logic          cmd_abort = 1'b0;
  logic [LW-1:0] cfg_packet_len  = '0;
  logic [CW-1:0] cfg_num_packets = '0;
  logic          cfg_continuous  = 1'b0;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [LW-1:0] pkt_config_reg;
  logic          mon_tvalid, mon_tready, mon_tlast;
  logic          busy, done_irq, err_overflow, err_cfg, err_timeout;
  logic [CW-1:0] packets_done;

  always #5 aclk = ~aclk;

  s2mm_acq_ctrl #(
    .DATA_W (DW), .LEN_W (LW), .CNT_W (CW), .DRAIN_TIMEOUT (TO)
  ) dut (
    .aclk (aclk), .aresetn (aresetn),
    .cmd_start (cmd_start), .cmd_abort (cmd_abort),
    .cfg_packet_len (cfg_packet_len), .cfg_num_packets (cfg_num_packets),
    .cfg_continuous (cfg_continuous),
    .s_axis_tdata (s_axis_tdata), .s_axis_tvalid (s_axis_tvalid), .s_axis_tready (s_axis_tready),
    .m_axis_tdata (m_axis_tdata), .m_axis_tvalid (m_axis_tvalid), .m_axis_tready (m_axis_tready),
    .pkt_config_reg (pkt_config_reg),
    .mon_tvalid (mon_tvalid), .mon_tready (mon_tready), .mon_tlast (mon_tlast),
    .busy (busy), .done_irq (done_irq), .packets_done (packets_done),
    .err_overflow (err_overflow), .err_cfg (err_cfg), .err_timeout (err_timeout)
  );

  // Source, sink and a packetizer model emitting tlast 3 edges after each packet's last word.
  logic          src_en   = 1'b0;
  logic          sink_rdy = 1'b1;
  logic          mon_en   = 1'b1;
  logic          clr      = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic [2:0]    tl_pipe  = '0;
  int            mlen = 1, mbeat = 0;
  int            cyc = 0, m_cnt = 0, tl_cnt = 0, tl_cyc = -1, last_m_cyc = -1;
  logic          w_mhs, w_bnd;

  assign s_axis_tvalid = src_en;
  assign s_axis_tdata  = src_data;
  assign m_axis_tready = sink_rdy;
  assign mon_tvalid    = tl_pipe[2] & mon_en;
  assign mon_tready    = tl_pipe[2] & mon_en;
  assign mon_tlast     = tl_pipe[2] & mon_en;
  assign w_mhs         = m_axis_tvalid && m_axis_tready;
  assign w_bnd         = w_mhs && (mbeat == mlen - 1);

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (s_axis_tvalid && s_axis_tready) src_data <= src_data + 1;
    if (clr) begin
      m_cnt   <= 0;
      tl_cnt  <= 0;
      mbeat   <= 0;
      tl_pipe <= '0;
    end else begin
      tl_pipe <= {tl_pipe[1:0], w_bnd};
      if (w_mhs) begin
        m_cnt      <= m_cnt + 1;
        last_m_cyc <= cyc;
        mbeat      <= (mbeat == mlen - 1) ? 0 : mbeat + 1;
      end
      if (mon_en && tl_pipe[2]) begin
        tl_cnt <= tl_cnt + 1;
        tl_cyc <= cyc;
      end
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge aclk);
    clr = 1'b0;
  endtask

  task automatic start(input logic [LW-1:0] len, input logic [CW-1:0] num,
                       input logic cont, input logic abort);
    cfg_packet_len  = len;
    cfg_num_packets = num;
    cfg_continuous  = cont;
    cmd_start = 1'b1;
    cmd_abort = abort;
    @(negedge aclk);
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input logic [LW-1:0] cfg_exp);
    int ok = 0;
    int viol = 0;
    for (int i = 0; i < maxc; i++) begin
      if (done_irq) begin
        ok = 1;
        break;
      end
      if (busy && pkt_config_reg !== cfg_exp) viol++;
      @(negedge aclk);
    end
    chk("done_seen", ok, 1);
    chk("cfg_hold", viol, 0);
  endtask

  task automatic wait_mcnt(input int target, input int maxc);
    int i = 0;
    while (m_cnt < target && i < maxc) begin
      @(negedge aclk);
      i++;
    end
    chk("mcnt_reach", (m_cnt >= target), 1);
  endtask

  typedef struct {
    logic [LW-1:0] len;
    logic [CW-1:0] num;
    logic          cont;
    logic          abort;
    logic          exp_err;
    logic          exp_busy;
    logic [LW-1:0] exp_cfg;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{len: 32'd0,          num: 16'd3, cont: 1'b0, abort: 1'b0, exp_err: 1'b1, exp_busy: 1'b0, exp_cfg: 32'd0};
    tbl[1] = '{len: 32'd10,         num: 16'd0, cont: 1'b0, abort: 1'b0, exp_err: 1'b1, exp_busy: 1'b0, exp_cfg: 32'd0};
    tbl[2] = '{len: 32'd0,          num: 16'd0, cont: 1'b1, abort: 1'b0, exp_err: 1'b1, exp_busy: 1'b0, exp_cfg: 32'd0};
    tbl[3] = '{len: 32'd5,          num: 16'd0, cont: 1'b1, abort: 1'b0, exp_err: 1'b0, exp_busy: 1'b1, exp_cfg: 32'd5};
    tbl[4] = '{len: 32'd7,          num: 16'd2, cont: 1'b0, abort: 1'b1, exp_err: 1'b0, exp_busy: 1'b1, exp_cfg: 32'd7};
    tbl[5] = '{len: 32'hFFFF_FFFF,  num: 16'd1, cont: 1'b0, abort: 1'b0, exp_err: 1'b0, exp_busy: 1'b1, exp_cfg: 32'hFFFF_FFFF};

    // Reset state, with the source valid so the gate is actually exercised.
    src_en = 1'b1;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_cfg", pkt_config_reg, 0);
    chk("rst_mvalid", m_axis_tvalid, 0);
    chk("rst_sready", s_axis_tready, 1);
    chk("rst_done", done_irq, 0);
    chk("rst_errs", {err_overflow, err_cfg, err_timeout}, 0);
    chk("rst_pdone", packets_done, 0);
    aresetn = 1'b1;
    src_en  = 1'b0;
    tick(2);

    // Config validation table.
    for (int i = 0; i < 6; i++) begin
      start(tbl[i].len, tbl[i].num, tbl[i].cont, tbl[i].abort);
      chk($sformatf("tbl%0d_errcfg", i), err_cfg, tbl[i].exp_err);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
      chk($sformatf("tbl%0d_cfg", i), pkt_config_reg, tbl[i].exp_cfg);
      if (tbl[i].exp_busy) begin
        @(negedge aclk);
        cmd_abort = 1'b1;
        @(negedge aclk);
        cmd_abort = 1'b0;
        wait_done(20, tbl[i].exp_cfg);
        tick(1);
        chk($sformatf("tbl%0d_idle", i), busy, 0);
      end else begin
        tick(1);
        chk($sformatf("tbl%0d_errpulse", i), err_cfg, 0);
      end
    end

    // len=10, num=3.
    mlen = 10;
    do_clr();
    src_en = 1'b1;
    start(32'd10, 16'd3, 1'b0, 1'b0);
    chk("t1_arm_cfg", pkt_config_reg, 10);
    chk("t1_arm_busy", busy, 1);
    cfg_packet_len = 32'd0;
    cmd_start = 1'b1;
    @(negedge aclk);
    cmd_start = 1'b0;
    chk("t1_start_busy", err_cfg, 0);
    wait_done(300, 32'd10);
    chk("t1_words", m_cnt, 30);
    chk("t1_tlast", tl_cnt, 3);
    chk("t1_pdone", packets_done, 3);
    chk("t1_irq_lat", cyc, tl_cyc + 1);
    tick(1);
    chk("t1_irq_width", done_irq, 0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_cfg", pkt_config_reg, 0);
    src_en = 1'b0;
    tick(2);

    // Continuous len=8, abort inside packet 2.
    mlen = 8;
    do_clr();
    src_en = 1'b1;
    start(32'd8, 16'd0, 1'b1, 1'b0);
    wait_mcnt(11, 100);
    chk("t2_pass_data", m_axis_tdata, src_data);
    chk("t2_pass_valid", m_axis_tvalid, 1);
    cmd_abort = 1'b1;
    @(negedge aclk);
    cmd_abort = 1'b0;
    wait_done(100, 32'd8);
    chk("t2_words", m_cnt, 16);
    chk("t2_pdone", packets_done, 2);
    tick(5);
    chk("t2_no_extra", m_cnt, 16);
    src_en = 1'b0;
    tick(2);

    // Sink stall -> sticky overflow, cleared by next start.
    mlen = 4;
    do_clr();
    src_en = 1'b1;
    start(32'd4, 16'd5, 1'b0, 1'b0);
    chk("t3_ovf_init", err_overflow, 0);
    tick(3);
    sink_rdy = 1'b0;
    tick(5);
    sink_rdy = 1'b1;
    chk("t3_ovf_set", err_overflow, 1);
    wait_done(200, 32'd4);
    chk("t3_ovf_sticky", err_overflow, 1);
    chk("t3_words", m_cnt, 20);
    chk("t3_pdone", packets_done, 5);
    tick(1);
    mlen = 2;
    do_clr();
    start(32'd2, 16'd1, 1'b0, 1'b0);
    chk("t3_ovf_clr", err_overflow, 0);
    wait_done(100, 32'd2);
    src_en = 1'b0;
    tick(2);

    // No tlast ever: drain timeout.
    mlen = 4;
    do_clr();
    mon_en = 1'b0;
    src_en = 1'b1;
    start(32'd4, 16'd1, 1'b0, 1'b0);
    wait_done(100, 32'd4);
    chk("t4_to_lat", cyc, last_m_cyc + 1 + TO);
    chk("t4_err_to", err_timeout, 1);
    chk("t4_pdone", packets_done, 0);
    tick(1);
    mon_en = 1'b1;
    src_en = 1'b0;
    tick(4);

    // Reset mid-packet, then a normal run.
    mlen = 10;
    do_clr();
    src_en = 1'b1;
    start(32'd10, 16'd2, 1'b0, 1'b0);
    wait_mcnt(2, 50);
    sink_rdy = 1'b0;
    @(negedge aclk);
    sink_rdy = 1'b1;
    wait_mcnt(4, 50);
    chk("t5_pre_ovf", err_overflow, 1);
    aresetn = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_cfg", pkt_config_reg, 0);
    chk("t5_rst_mvalid", m_axis_tvalid, 0);
    chk("t5_rst_sready", s_axis_tready, 1);
    chk("t5_rst_ovf", err_overflow, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    mlen = 3;
    do_clr();
    start(32'd3, 16'd2, 1'b0, 1'b0);
    wait_done(100, 32'd3);
    chk("t5_words", m_cnt, 6);
    chk("t5_pdone", packets_done, 2);
    src_en = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
